mode_select_controller: RTL
===========================

Name: mode_select_controller

Overview:
Front-panel input stage that generates the 4-bit mode_select code consumed by the output mode decoder. It synchronises and debounces three pushbuttons and edge-detects each press. Presses step the display source (XADC/PWM/R2R) and the data type (RAW/AVG/SCALED), and toggle OFF mode. The block holds the selected mode in registers and drives mode_select, plus a one-cycle strobe whenever that code changes.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive synchronised cycles a button level must hold before it is accepted (min 2)
SCAN_CYCLES, 200_000_000, dwell time per mode in auto-scan (only with MODE_AUTO_SCAN_EN)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
btn_source  input  1  raw pushbutton, active-high; advances source
btn_data  input  1  raw pushbutton, active-high; advances data type
btn_off  input  1  raw pushbutton, active-high; toggles OFF/ACTIVE
scan_en  input  1  auto-scan enable level (present only with MODE_AUTO_SCAN_EN)
mode_select  output  4  {source[1:0], data[1:0]}; 4'b0000 = OFF
mode_changed  output  1  one-cycle pulse when mode_select changes value

Behaviour:
- Reset (reset_n low, asynchronous): state = OFF, source = 2'b00 (XADC), data = 2'b01 (RAW), all synchroniser/debounce/edge registers = 0, counters = 0, mode_select = 4'b0000, mode_changed = 0.
- Per-button input path:
  - 2-flop synchroniser.
  - Debounce counter: counts consecutive cycles in which the synced level differs from the debounced level. It clears whenever the two are equal. The debounced level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle, and the counter clears.
  - Press pulse = rising edge of the debounced level, registered, so it lasts exactly one cycle.
  - Release is debounced the same way; a release produces no pulse.
- Latency: a clean raw rising edge changes mode_select exactly DEBOUNCE_CYCLES + 3 cycles later.
- Glitch handling: a raw glitch shorter than DEBOUNCE_CYCLES synced cycles produces no pulse.
- Held button: produces exactly one pulse; no auto-repeat.
- Source register cycles 00 -> 01 -> 10 -> 00; value 11 is unreachable.
- Data register cycles 01 -> 10 -> 11 -> 01; value 00 is unreachable.
- FSM states OFF and ACTIVE:
  - OFF: mode_select = 0000. off_press -> ACTIVE. source_press and data_press are ignored and do not change the registers.
  - ACTIVE: mode_select = {source, data}. source_press advances source; data_press advances data; both may act in the same cycle. off_press -> OFF.
- Priority: off_press in the same cycle as other presses wins, and the other presses are discarded.
- Retention: source and data are kept across OFF, so re-entering ACTIVE restores the last mode.
- mode_select is registered and updates the cycle after the press pulse.
- mode_changed is registered and is high for the one cycle in which mode_select first shows a new value. It is never high when a press leaves the code unchanged.
- Reset asserted mid-debounce or mid-press: all in-flight state is lost. After release, a button held through reset needs a full DEBOUNCE_CYCLES window before it registers, and then does register as a press.

Optional Feature:
MODE_AUTO_SCAN_EN
- Defined:
  - Adds the scan_en port and a scan timer.
  - While ACTIVE with scan_en high, the timer counts to SCAN_CYCLES-1. It then advances data; when data wraps 11 -> 01, source advances in the same cycle. The timer then restarts at 0.
  - All 9 active modes are visited in order XADC_RAW .. R2R_SCL, then wrap.
  - Any press pulse, or scan_en low, or OFF state, clears the timer to 0.
  - mode_changed pulses on each scan step.
- Undefined: no scan_en port, no timer, and behaviour is purely button-driven.

Test Plan:
1. DEBOUNCE_CYCLES=4: reset, btn_off high and held -> mode_select 0000 -> 0001 exactly 7 cycles after the edge; mode_changed high for 1 cycle; holding 100 cycles gives no further change.
2. ACTIVE at 0001: btn_source pressed 3 times (clean) -> 0101, 1001, 0001. btn_data pressed 3 times from 0001 -> 0010, 0011, 0001.
3. btn_data glitch of 3 synced cycles with DEBOUNCE_CYCLES=4 -> no change and no mode_changed. Bouncy press (1-2 cycle toggles, then stable) -> exactly one step.
4. At 1010, btn_off and btn_source released-to-pressed in the same cycle -> 0000 (source unchanged). In OFF, btn_source/btn_data presses -> stays 0000. btn_off again -> 1010 restored.
5. reset_n pulsed low mid-debounce while at 0111 -> mode_select 0000 immediately (asynchronous), source/data back to XADC/RAW. After btn_off -> 0001.
6. MODE_AUTO_SCAN_EN, SCAN_CYCLES=8, ACTIVE at 1011, scan_en=1 -> 0001 after 8 cycles, then 0010, 0011, 0101 at 8-cycle spacing. A press mid-interval restarts the 8-cycle dwell.

Source files
------------

// File: rtl/mode_select_controller_if.sv
// Front-panel bus between the raw pushbuttons and mode_select_controller.
// scan_en exists only when MODE_AUTO_SCAN_EN is defined.
interface mode_select_controller_if;
   logic       btn_source;
   logic       btn_data;
   logic       btn_off;
`ifdef MODE_AUTO_SCAN_EN
   logic       scan_en;
`endif
   logic [3:0] mode_select;
   logic       mode_changed;

   modport master (
`ifdef MODE_AUTO_SCAN_EN
      output scan_en,
`endif
      output btn_source, btn_data, btn_off,
      input  mode_select, mode_changed
   );

   modport slave (
`ifdef MODE_AUTO_SCAN_EN
      input  scan_en,
`endif
      input  btn_source, btn_data, btn_off,
      output mode_select, mode_changed
   );
endinterface

// File: rtl/mode_select_controller.sv
// Debounced three-button front panel producing the 4-bit mode_select code.
// Optional timed auto-scan through all active modes: define MODE_AUTO_SCAN_EN.
module mode_select_controller #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
`ifdef MODE_AUTO_SCAN_EN
   , parameter int SCAN_CYCLES = 200_000_000
`endif
) (
   input  logic                     clk,
   input  logic                     reset_n,
   mode_select_controller_if.slave  bus
);

   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {ST_OFF, ST_ACTIVE} state_t;

   // Button index: 0 = source, 1 = data, 2 = off
   logic [2:0]      btn_raw;
   logic [2:0]      sync_p0;
   logic [2:0]      sync_p1;
   logic [2:0]      deb_p2;
   logic [2:0]      press_p3;
   logic [DB_W-1:0] db_cnt [3];

   state_t          state, state_nx;
   logic [1:0]      source, source_nx;
   logic [1:0]      data, data_nx;
   logic [3:0]      mode_nx;
   logic            any_press;

   function automatic logic [1:0] adv_source(input logic [1:0] s);
      return (s == 2'b10 || s == 2'b11) ? 2'b00 : s + 2'b01;
   endfunction

   function automatic logic [1:0] adv_data(input logic [1:0] d);
      return (d == 2'b11 || d == 2'b00) ? 2'b01 : d + 2'b01;
   endfunction

   assign btn_raw   = {bus.btn_off, bus.btn_data, bus.btn_source};
   assign any_press = |press_p3;

   // p0/p1: synchroniser, p2: debounced level, p3: one-cycle press pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_p0  <= '0;
         sync_p1  <= '0;
         deb_p2   <= '0;
         press_p3 <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync_p0  <= btn_raw;
         sync_p1  <= sync_p0;
         press_p3 <= '0;
         for (int i = 0; i < 3; i++) begin
            if (sync_p1[i] == deb_p2[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_cnt[i]   <= '0;
               deb_p2[i]   <= sync_p1[i];
               press_p3[i] <= sync_p1[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef MODE_AUTO_SCAN_EN
   localparam int              SC_W    = $clog2(SCAN_CYCLES);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_CYCLES - 1);

   logic [SC_W-1:0] scan_timer;
   logic            scan_run;
   logic            scan_step;

   assign scan_run  = (state == ST_ACTIVE) && bus.scan_en && !any_press;
   assign scan_step = scan_run && (scan_timer == SC_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                   scan_timer <= '0;
      else if (!scan_run || scan_step) scan_timer <= '0;
      else                            scan_timer <= scan_timer + 1'b1;
   end
`endif

   // off_press outranks the other presses in the same cycle
   always_comb begin
      state_nx  = state;
      source_nx = source;
      data_nx   = data;
      if (state == ST_OFF) begin
         if (press_p3[2]) state_nx = ST_ACTIVE;
      end else if (press_p3[2]) begin
         state_nx = ST_OFF;
      end else begin
         if (press_p3[0]) source_nx = adv_source(source);
         if (press_p3[1]) data_nx   = adv_data(data);
`ifdef MODE_AUTO_SCAN_EN
         if (scan_step) begin
            data_nx = adv_data(data);
            if (data == 2'b11) source_nx = adv_source(source);
         end
`endif
      end
      mode_nx = (state_nx == ST_ACTIVE) ? {source_nx, data_nx} : 4'b0000;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= ST_OFF;
         source           <= 2'b00;
         data             <= 2'b01;
         bus.mode_select  <= 4'b0000;
         bus.mode_changed <= 1'b0;
      end else begin
         state            <= state_nx;
         source           <= source_nx;
         data             <= data_nx;
         bus.mode_select  <= mode_nx;
         bus.mode_changed <= (mode_nx != bus.mode_select);
      end
   end

endmodule
